// File: rtl/nios_system_pio_ext.sv
// Parametrised Avalon-MM PIO: per-bit direction, atomic set/clear, synchronised
// input readback, edge capture with maskable irq and a shared blink generator.
module nios_system_pio_ext #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               BLINK_CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [BLINK_CNT_W-1:0] CNT_ONE = 1;

  logic                   wr_en;
  logic [WIDTH-1:0]       wd;
  logic                   unused_wd;

  logic [WIDTH-1:0]       data_out_reg, data_out_next;
  logic [WIDTH-1:0]       dir_reg;
  logic [WIDTH-1:0]       irq_mask_reg;
  logic [WIDTH-1:0]       edge_cap_reg, edge_cap_next;
  logic [WIDTH-1:0]       blink_en_reg;
  logic [BLINK_CNT_W-1:0] blink_period_reg;
  logic [BLINK_CNT_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic                   phase_reg, phase_next;

  logic [WIDTH-1:0]       sync_meta_reg;
  logic [WIDTH-1:0]       in_sync_reg;
  logic [WIDTH-1:0]       in_prev_reg;
  logic [WIDTH-1:0]       edge_det;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_out_next = data_out_reg;
    if (wr_en) begin
      case (address)
        3'd0:    data_out_next = wd;
        3'd4:    data_out_next = data_out_reg | wd;
        3'd5:    data_out_next = data_out_reg & ~wd;
        default: data_out_next = data_out_reg;
      endcase
    end
  end

  // A fresh edge overrides a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    edge_cap_next = edge_cap_reg;
    if (wr_en && address == 3'd3)
      edge_cap_next = edge_cap_reg & ~wd;
    edge_cap_next = edge_cap_next | edge_det;
  end

  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if ((wr_en && address == 3'd7) || blink_period_reg == '0) begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
    end else if (blink_cnt_reg == blink_period_reg - CNT_ONE) begin
      blink_cnt_next = '0;
      phase_next     = ~phase_reg;
    end else begin
      blink_cnt_next = blink_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_reg     <= RESET_VALUE;
      dir_reg          <= '0;
      irq_mask_reg     <= '0;
      edge_cap_reg     <= '0;
      blink_en_reg     <= '0;
      blink_period_reg <= '0;
      blink_cnt_reg    <= '0;
      phase_reg        <= 1'b0;
      sync_meta_reg    <= '0;
      in_sync_reg      <= '0;
      in_prev_reg      <= '0;
    end else begin
      data_out_reg  <= data_out_next;
      edge_cap_reg  <= edge_cap_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      sync_meta_reg <= in_port;
      in_sync_reg   <= sync_meta_reg;
      in_prev_reg   <= in_sync_reg;
      if (wr_en) begin
        case (address)
          3'd1:    dir_reg          <= wd;
          3'd2:    irq_mask_reg     <= wd;
          3'd6:    blink_en_reg     <= wd;
          3'd7:    blink_period_reg <= writedata[BLINK_CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (EDGE_TYPE == 0) begin : g_rise
        assign edge_det[gi] = in_sync_reg[gi] & ~in_prev_reg[gi];
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_det[gi] = ~in_sync_reg[gi] & in_prev_reg[gi];
      end else begin : g_any
        assign edge_det[gi] = in_sync_reg[gi] ^ in_prev_reg[gi];
      end
      assign out_port[gi] = data_out_reg[gi] ^ (blink_en_reg[gi] & phase_reg);
    end
  endgenerate

  assign oe  = dir_reg;
  assign irq = |(edge_cap_reg & irq_mask_reg);

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = (data_out_reg & dir_reg) | (in_sync_reg & ~dir_reg);
      3'd1:    readdata[WIDTH-1:0] = dir_reg;
      3'd2:    readdata[WIDTH-1:0] = irq_mask_reg;
      3'd3:    readdata[WIDTH-1:0] = edge_cap_reg;
      3'd6:    readdata[WIDTH-1:0] = blink_en_reg;
      3'd7:    readdata[BLINK_CNT_W-1:0] = blink_period_reg;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_system_pio_ext.sv
// Directed bench for nios_system_pio_ext: a register-level model is checked
// against the outputs every cycle, with literal expectations at key points.
module tb_nios_system_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  logic [31:0] rd32, out32, oe32;
  logic        irq32;
  logic [31:0] in32 = '0;
  logic [31:0] rd4;
  logic [3:0]  out4, oe4;
  logic        irq4;
  logic [3:0]  in4 = '0;

  nios_system_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .BLINK_CNT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq));

  nios_system_pio_ext #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd32),
    .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32));

  nios_system_pio_ext #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd4),
    .in_port(in4), .out_port(out4), .oe(oe4), .irq(irq4));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Model state: register contents, pin history (newest first) and blink timing.
  logic [7:0]  m_data, m_dir, m_mask, m_cap, m_ben;
  logic [23:0] m_period;
  int          m_cyc, m_bstart;
  logic [7:0]  pin_hist [0:2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic m_phase();
    if (m_period == 24'd0) return 1'b0;
    return (((m_cyc - m_bstart) / int'(m_period)) % 2) == 1;
  endfunction

  function automatic logic [7:0] m_out();
    return m_data ^ (m_ben & {8{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, (m_data & m_dir) | (pin_hist[1] & ~m_dir)};
      3'd1:    return {24'h0, m_dir};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_cap};
      3'd6:    return {24'h0, m_ben};
      3'd7:    return {8'h0, m_period};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= 8'hA5; m_dir <= '0; m_mask <= '0; m_cap <= '0; m_ben <= '0;
      m_period <= '0; m_cyc <= 0; m_bstart <= 0;
      pin_hist[0] <= '0; pin_hist[1] <= '0; pin_hist[2] <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      pin_hist[0] <= in_port;
      pin_hist[1] <= pin_hist[0];
      pin_hist[2] <= pin_hist[1];
      m_cap <= (m_cap & ~((chipselect && !write_n && address == 3'd3) ? writedata[7:0] : 8'h00))
               | (pin_hist[1] & ~pin_hist[2]);
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[7:0];
          3'd1: m_dir  <= writedata[7:0];
          3'd2: m_mask <= writedata[7:0];
          3'd4: m_data <= m_data | writedata[7:0];
          3'd5: m_data <= m_data & ~writedata[7:0];
          3'd6: m_ben  <= writedata[7:0];
          3'd7: begin m_period <= writedata[23:0]; m_bstart <= m_cyc + 1; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc out_port", {24'h0, out_port}, {24'h0, m_out()});
      chk("cyc oe", {24'h0, oe}, {24'h0, m_dir});
      chk("cyc irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr %0d data %08h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] lit);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk({name, " model"}, readdata, m_read(a));
    chk(name, readdata, lit);
    $display("read addr %0d data %08h", a, readdata);
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst out_port", {24'h0, out_port}, 32'hA5);
    chk("rst oe", {24'h0, oe}, 32'h0);
    chk("rst irq", {31'h0, irq}, 32'h0);
    rd(3'd0, "rst data", 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Atomic set/clear
    wr(3'd1, 32'hFF); wr(3'd0, 32'h0F); wr(3'd4, 32'h30); wr(3'd5, 32'h03);
    chk("setclr out_port", {24'h0, out_port}, 32'h3C);
    rd(3'd4, "outset read", 32'h0);
    rd(3'd5, "outclr read", 32'h0);
    rd(3'd0, "setclr data", 32'h3C);

    // Mixed direction readback
    wr(3'd1, 32'hF0); wr(3'd0, 32'hA0);
    @(negedge clk); in_port = 8'h05;
    repeat (3) @(negedge clk);
    rd(3'd0, "mixed data", 32'hA5);
    in_port = 8'h00;
    wr(3'd3, 32'hFF);
    rd(3'd3, "cap cleared", 32'h0);

    // Rising edge capture and irq
    wr(3'd2, 32'h01);
    @(negedge clk); in_port = 8'h01;
    repeat (2) @(negedge clk);
    chk("irq before capture", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq after capture", {31'h0, irq}, 32'h1);
    rd(3'd3, "cap set", 32'h01);
    wr(3'd3, 32'h01);
    chk("irq after w1c", {31'h0, irq}, 32'h0);

    // Set wins over simultaneous clear
    @(negedge clk); in_port = 8'h00;
    repeat (3) @(negedge clk);
    in_port = 8'h01;
    repeat (4) @(negedge clk);
    rd(3'd3, "cap reset-up", 32'h01);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'h01;
    @(negedge clk);
    wr(3'd3, 32'h01);
    rd(3'd3, "cap set wins", 32'h01);
    chk("irq set wins", {31'h0, irq}, 32'h1);

    // Asynchronous reset with irq pending
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    chk("async rst irq", {31'h0, irq}, 32'h0);
    chk("async rst out_port", {24'h0, out_port}, 32'hA5);
    chk("async rst oe", {24'h0, oe}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    in_port = 8'h00;

    // Blink
    wr(3'd1, 32'hFF); wr(3'd0, 32'h00); wr(3'd6, 32'h81); wr(3'd7, 32'h4);
    chk("blink t0", {24'h0, out_port}, 32'h00);
    repeat (3) @(negedge clk);
    chk("blink t3", {24'h0, out_port}, 32'h00);
    @(negedge clk);
    chk("blink t4", {24'h0, out_port}, 32'h81);
    repeat (3) @(negedge clk);
    chk("blink t7", {24'h0, out_port}, 32'h81);
    @(negedge clk);
    chk("blink t8", {24'h0, out_port}, 32'h00);
    rd(3'd7, "period read", 32'h4);
    rd(3'd6, "blink_en read", 32'h81);
    wr(3'd7, 32'h0);
    repeat (5) @(negedge clk);
    chk("blink off", {24'h0, out_port}, 32'h00);

    // Width handling
    wr(3'd1, 32'hFFFFFFFF); wr(3'd0, 32'hFFFFFFFF);
    chk("w32 out_port", out32, 32'hFFFFFFFF);
    @(negedge clk);
    address = 3'd0; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk("w4 readdata", rd4, 32'h0000000F);
    chk("w32 readdata", rd32, 32'hFFFFFFFF);
    chk("w8 readdata", readdata, m_read(3'd0));
    $display("read addr 0 w4 %08h w32 %08h", rd4, rd32);
    chipselect = 1'b0;

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_ext.md
Name: nios_system_pio_ext

Overview:
- Parametrised successor to the fixed 8-bit output-only PIO slave. Avalon-MM slave on the Nios II system bus.
- Adds per-bit direction control, atomic set and clear writes, synchronised input readback, edge capture with maskable interrupt, and a shared hardware blink generator.
- Drives board LEDs and GPIO headers and reads switches/keys, so no software read-modify-write is needed.

Parameters:
- WIDTH, 8, port width in bits, legal range 1..32.
- RESET_VALUE, 0, reset value of the DATA output register (WIDTH bits).
- EDGE_TYPE, 0, edge capture type: 0 = rising, 1 = falling, 2 = any.
- BLINK_CNT_W, 24, width of the blink period register and its counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero-extended.
- in_port  in  WIDTH  external inputs, asynchronous to clk.
- out_port  out  WIDTH  pin output value.
- oe  out  WIDTH  per-bit output enable (= DIR).
- irq  out  1  level interrupt.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - Reset values: data_out = RESET_VALUE; DIR, IRQ_MASK, EDGE_CAP, BLINK_EN and BLINK_PERIOD = 0; blink counter and phase = 0; both synchroniser stages = 0.
  - Output values at reset: out_port = RESET_VALUE, oe = 0, irq = 0.
- Write: occurs when chipselect=1 and write_n=0, on the same clk edge, using writedata[WIDTH-1:0]. Bits above WIDTH are ignored.
- Register map:
  - 0 DATA. Write: data_out <= wd. Read: (data_out & DIR) | (in_sync & ~DIR).
  - 1 DIR. Read/write; 1 = output.
  - 2 IRQ_MASK. Read/write.
  - 3 EDGE_CAP. Read returns captured edges; write-1-to-clear.
  - 4 OUTSET. Write: data_out <= data_out | wd. Reads 0.
  - 5 OUTCLR. Write: data_out <= data_out & ~wd. Reads 0.
  - 6 BLINK_EN. Read/write, per bit.
  - 7 BLINK_PERIOD. Read/write, BLINK_CNT_W bits.
- Readdata: combinational, zero wait states, zero-extended to 32 bits, independent of chipselect.
- Input path: 2-flop synchroniser produces in_sync, plus a delay stage in_prev.
  - Rising edge = in_sync & ~in_prev; falling edge = ~in_sync & in_prev; any = XOR of the two.
  - An edge is detected 2 clk after the pin changes and sets EDGE_CAP on the following edge.
  - Edges are captured regardless of DIR.
- EDGE_CAP update: EDGE_CAP <= (EDGE_CAP & ~clr) | edge.
  - If a new edge coincides with a W1C of the same bit, the set wins and the bit stays 1.
- irq = |(EDGE_CAP & IRQ_MASK). Registered-path only, no combinational path from writedata.
- Blink generator:
  - If BLINK_PERIOD = 0: counter = 0 and phase = 0 (no blink).
  - Otherwise the counter increments every clk. When counter = BLINK_PERIOD-1 it wraps to 0 and phase toggles, so the full blink period is 2*BLINK_PERIOD clk.
  - Writing BLINK_PERIOD forces counter = 0 and phase = 0 on that edge.
- Output: out_port = data_out ^ (BLINK_EN & {WIDTH{phase}}). Blink applies only to the driven value; oe = DIR.
- DATA readback of output bits returns data_out, not the blinked value.
- Addresses 4 and 5 never alter DIR or EDGE_CAP.
- Reset mid-operation: all state clears immediately. A pending irq deasserts asynchronously.

Test Plan:
- Reset values (WIDTH=8, RESET_VALUE=8'hA5): assert reset -> out_port=A5, oe=00, irq=0; read addr 0 -> 0x00000000 (DIR=0, in_port=0 synced).
- Set/clear (DIR=FF): write DATA=0x0F, OUTSET=0x30, OUTCLR=0x03 -> out_port=0x3C after the third write; reads of addresses 4 and 5 -> 0.
- Mixed readback: DIR=0xF0, DATA=0xA0, in_port=0x05 held ≥3 clk -> read addr 0 = 0x000000A5.
- Edge and irq (EDGE_TYPE=0): IRQ_MASK=0x01, in_port[0] 0→1 -> EDGE_CAP=0x01 and irq=1 by the 3rd clk. Write EDGE_CAP=0x01 -> irq=0 next clk. Repeat with W1C on the same clk as a new edge -> bit stays 1.
- Blink: DIR=FF, DATA=0x00, BLINK_EN=0x81, BLINK_PERIOD=4 -> out_port alternates 0x00/0x81 every 4 clk. BLINK_PERIOD=0 -> out_port holds 0x00.
- Width (WIDTH=32, writedata=0xFFFFFFFF to DATA, DIR): out_port=FFFFFFFF; with WIDTH=4 -> readdata[31:4]=0.
